// File: rtl/gate_check_pkg.sv
// Shared types and constants for the gate truth-table checker.
// Holds the sequencer state encoding and the default AND truth table.
package gate_check_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_e;

    // Bit k is the expected gate output for input vector k.
    localparam logic [3:0] AND_TT = 4'b1000;

    // Wide enough for SETTLE_CYCLES up to 15.
    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/gate_truth_table_checker.sv
// Sweeps every input vector of a small combinational gate, holds each one
// for a settle window, and compares the gate output with a truth table.
module gate_truth_table_checker
    import gate_check_pkg::*;
#(
    parameter int unsigned N_IN = 2,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [(1<<N_IN)-1:0] TRUTH_TABLE = AND_TT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            fail_valid,
    output logic [N_IN-1:0] first_fail_idx
);

    localparam logic [N_IN-1:0]  LAST_VEC = '1;
    localparam logic [N_IN:0]    ERR_MAX = {1'b1, {N_IN{1'b0}}};
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [N_IN-1:0]  vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [N_IN:0]    err_q, err_d;
    logic             fv_q, fv_d;
    logic [N_IN-1:0]  ffi_q, ffi_d;
    logic             mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            ffi_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            ffi_q   <= ffi_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        cnt_d    = cnt_q;
        pass_d   = pass_q;
        err_d    = err_q;
        fv_d     = fv_q;
        ffi_d    = ffi_q;
        busy_d   = (state_q != IDLE);
        done_d   = (state_q == DONE);
        mismatch = 1'b0;

        unique case (state_q)
            IDLE: begin
                // busy lags the state by one cycle, so it still covers the
                // done pulse while the FSM already sits in IDLE.
                if (start && !busy_q) begin
                    state_d = SETTLE;
                    vec_d   = '0;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    fv_d    = 1'b0;
                    ffi_d   = '0;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                mismatch = (dut_out != TRUTH_TABLE[vec_q]);
                if (mismatch) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + 1'b1;
                    end
                    if (!fv_q) begin
                        fv_d  = 1'b1;
                        ffi_d = vec_q;
                    end
                end
                if (vec_q == LAST_VEC) begin
                    state_d = DONE;
                end else begin
                    vec_d   = vec_q + 1'b1;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            DONE: begin
                pass_d  = (err_q == '0);
                state_d = IDLE;
            end
        endcase
    end

    assign dut_in         = vec_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign fail_valid     = fv_q;
    assign first_fail_idx = ffi_q;

endmodule
